// File: rtl/grf_write_scheduler_pkg.sv
// Shared types for the GRF write scheduler: register-address width, default data
// width and the write-back entry record held in the mul/div result FIFO.
package grf_write_scheduler_pkg;

    localparam int REG_AW   = 5;
    localparam int GRF_XLEN = 32;

    typedef struct packed {
        logic                valid;
        logic [REG_AW-1:0]   addr;
        logic [GRF_XLEN-1:0] data;
        logic [GRF_XLEN-1:0] pc;
    } wb_entry_t;

    // $0 is hardwired; requests aimed at it are swallowed everywhere
    function automatic logic reg_writable(input logic [REG_AW-1:0] addr);
        return addr != REG_AW'(0);
    endfunction

endpackage

// File: rtl/grf_wb_fifo.sv
// Mul/div result FIFO: per-entry squash by address, skip of squashed head entries,
// occupancy of live entries, and an oldest-first view of the storage for bypass.
module grf_wb_fifo
    import grf_write_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [REG_AW-1:0]         push_addr,
    input  logic [GRF_XLEN-1:0]       push_data,
    input  logic [GRF_XLEN-1:0]       push_pc,
    input  logic                      pop,
    input  logic                      kill_en,
    input  logic [REG_AW-1:0]         kill_addr,
    output logic                      full,
    output wb_entry_t                 head,
    output logic                      kill_hit,
    output logic [$clog2(DEPTH):0]    pending,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [REG_AW-1:0]         ent_addr [DEPTH],
    output logic [GRF_XLEN-1:0]       ent_data [DEPTH]
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    wb_entry_t         mem_r [DEPTH];
    wb_entry_t         mem_s [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     pend_r;
    logic [PW-1:0]     pend_s;
    logic [PW-1:0]     occ_s;
    logic [PW-1:0]     lead_s;
    logic [PW-1:0]     pop_n_s;
    logic [AW-1:0]     head_idx_s;
    logic [AW-1:0]     rel_s [DEPTH];
    logic              seen_s;

    assign occ_s   = wr_ptr_r - rd_ptr_r;
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pending = pend_r;

    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        logic [AW-1:0] idx_s;
        assign idx_s        = rd_ptr_r[AW-1:0] + AW'(g);
        assign ent_valid[g] = mem_r[idx_s].valid;
        assign ent_addr[g]  = mem_r[idx_s].addr;
        assign ent_data[g]  = mem_r[idx_s].data;
        assign rel_s[g]     = AW'(g) - rd_ptr_r[AW-1:0];
    end

    // Count squashed entries sitting in front of the first live one
    always_comb begin
        lead_s = PW'(0);
        seen_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!seen_s && (PW'(i) < occ_s)) begin
                if (ent_valid[i]) begin
                    seen_s = 1'b1;
                end else begin
                    lead_s = lead_s + PW'(1);
                end
            end else begin
                seen_s = seen_s;
            end
        end
    end

    assign head_idx_s = rd_ptr_r[AW-1:0] + lead_s[AW-1:0];
    assign pop_n_s    = lead_s + ((pop && seen_s) ? PW'(1) : PW'(0));

    // Head view: first live entry, valid only if one exists
    always_comb begin
        head       = mem_r[head_idx_s];
        head.valid = seen_s;
    end

    // Next storage image: retire popped slots, squash by address, then append
    always_comb begin
        kill_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_s[i] = mem_r[i];
            if ({1'b0, rel_s[i]} < pop_n_s) begin
                mem_s[i].valid = 1'b0;
            end else begin
                mem_s[i].valid = mem_r[i].valid;
            end
            if (kill_en && mem_r[i].valid && (mem_r[i].addr == kill_addr)) begin
                mem_s[i].valid = 1'b0;
                kill_hit       = 1'b1;
            end else begin
                kill_hit = kill_hit;
            end
        end
        if (push) begin
            mem_s[wr_ptr_r[AW-1:0]] = '{valid: 1'b1, addr: push_addr, data: push_data, pc: push_pc};
        end else begin
            mem_s[wr_ptr_r[AW-1:0]] = mem_s[wr_ptr_r[AW-1:0]];
        end
        pend_s = PW'(0);
        for (int i = 0; i < DEPTH; i++) begin
            pend_s = pend_s + PW'(mem_s[i].valid);
        end
    end

    // Pointer, occupancy and storage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            pend_r   <= PW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            wr_ptr_r <= wr_ptr_r + (push ? PW'(1) : PW'(0));
            rd_ptr_r <= rd_ptr_r + pop_n_s;
            pend_r   <= pend_s;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= mem_s[i];
            end
        end
    end

endmodule

// File: rtl/grf_write_scheduler.sv
// Merges pipeline WB and buffered mul/div results into one registered GRF write per
// cycle, and answers two bypass queries against writes not yet in the register file.
module grf_write_scheduler
    import grf_write_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = GRF_XLEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pipe_valid,
    input  logic [REG_AW-1:0]       pipe_addr,
    input  logic [XLEN-1:0]         pipe_data,
    input  logic [XLEN-1:0]         pipe_pc,
    input  logic                    md_valid,
    output logic                    md_ready,
    input  logic [REG_AW-1:0]       md_addr,
    input  logic [XLEN-1:0]         md_data,
    input  logic [XLEN-1:0]         md_pc,
    output logic                    grf_we,
    output logic [REG_AW-1:0]       grf_addr,
    output logic [XLEN-1:0]         grf_wdata,
    output logic [XLEN-1:0]         grf_pc,
    input  logic [REG_AW-1:0]       q1_addr,
    output logic                    q1_hit,
    output logic [XLEN-1:0]         q1_data,
    input  logic [REG_AW-1:0]       q2_addr,
    output logic                    q2_hit,
    output logic [XLEN-1:0]         q2_data,
    output logic [$clog2(DEPTH):0]  pending_cnt,
    output logic                    squash
);

    logic                  grf_we_r;
    logic [REG_AW-1:0]     grf_addr_r;
    logic [XLEN-1:0]       grf_wdata_r;
    logic [XLEN-1:0]       grf_pc_r;
    logic                  squash_r;

    logic                  full_s;
    wb_entry_t             head_s;
    logic                  kill_hit_s;
    logic [DEPTH-1:0]      ent_valid_s;
    logic [REG_AW-1:0]     ent_addr_s [DEPTH];
    logic [XLEN-1:0]       ent_data_s [DEPTH];

    logic                  pipe_we_s;
    logic                  md_take_s;
    logic                  issue_s;
    logic                  pop_s;
    logic                  direct_s;
    logic                  push_s;
    logic [REG_AW-1:0]     iss_addr_s;
    logic [XLEN-1:0]       iss_data_s;
    logic [XLEN-1:0]       iss_pc_s;
    logic [XLEN:0]         q1_res_s;
    logic [XLEN:0]         q2_res_s;

    assign md_ready  = !full_s;
    assign pipe_we_s = pipe_valid && reg_writable(pipe_addr);
    // $0 results are still handshaked so the producer never stalls on them
    assign md_take_s = md_valid && md_ready && reg_writable(md_addr);
    assign push_s    = md_take_s && !direct_s;

    grf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_addr (md_addr),
        .push_data (md_data),
        .push_pc   (md_pc),
        .pop       (pop_s),
        .kill_en   (pipe_we_s),
        .kill_addr (pipe_addr),
        .full      (full_s),
        .head      (head_s),
        .kill_hit  (kill_hit_s),
        .pending   (pending_cnt),
        .ent_valid (ent_valid_s),
        .ent_addr  (ent_addr_s),
        .ent_data  (ent_data_s)
    );

    // Issue select: pipe, then oldest live FIFO entry, then direct mul/div
    always_comb begin
        issue_s    = 1'b0;
        pop_s      = 1'b0;
        direct_s   = 1'b0;
        iss_addr_s = grf_addr_r;
        iss_data_s = grf_wdata_r;
        iss_pc_s   = grf_pc_r;
        if (pipe_we_s) begin
            issue_s    = 1'b1;
            iss_addr_s = pipe_addr;
            iss_data_s = pipe_data;
            iss_pc_s   = pipe_pc;
        end else if (head_s.valid) begin
            issue_s    = 1'b1;
            pop_s      = 1'b1;
            iss_addr_s = head_s.addr;
            iss_data_s = head_s.data;
            iss_pc_s   = head_s.pc;
        end else if (md_take_s) begin
            issue_s    = 1'b1;
            direct_s   = 1'b1;
            iss_addr_s = md_addr;
            iss_data_s = md_data;
            iss_pc_s   = md_pc;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Output register; address/data/pc hold when nothing issues
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grf_we_r    <= 1'b0;
            grf_addr_r  <= REG_AW'(0);
            grf_wdata_r <= XLEN'(0);
            grf_pc_r    <= XLEN'(0);
            squash_r    <= 1'b0;
        end else begin
            grf_we_r    <= issue_s;
            grf_addr_r  <= iss_addr_s;
            grf_wdata_r <= iss_data_s;
            grf_pc_r    <= iss_pc_s;
            squash_r    <= kill_hit_s;
        end
    end

    assign grf_we    = grf_we_r;
    assign grf_addr  = grf_addr_r;
    assign grf_wdata = grf_wdata_r;
    assign grf_pc    = grf_pc_r;
    assign squash    = squash_r;

    // Newest match wins: FIFO entries are scanned oldest-first so later hits override
    function automatic logic [XLEN:0] lookup(input logic [REG_AW-1:0] qa);
        logic [XLEN:0] res;
        res = {1'b0, XLEN'(0)};
        if (grf_we_r && (grf_addr_r == qa)) begin
            res = {1'b1, grf_wdata_r};
        end else begin
            res = res;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_s[i] && (ent_addr_s[i] == qa)) begin
                res = {1'b1, ent_data_s[i]};
            end else begin
                res = res;
            end
        end
        if (!reg_writable(qa)) begin
            res = {1'b0, XLEN'(0)};
        end else begin
            res = res;
        end
        return res;
    endfunction

    // Bypass query ports
    always_comb begin
        q1_res_s = lookup(q1_addr);
        q2_res_s = lookup(q2_addr);
    end

    assign q1_hit  = q1_res_s[XLEN];
    assign q1_data = q1_res_s[XLEN-1:0];
    assign q2_hit  = q2_res_s[XLEN];
    assign q2_data = q2_res_s[XLEN-1:0];

endmodule

// File: tb/tb_grf_write_scheduler.sv
// Bench for grf_write_scheduler: directed vector table, reset-mid-operation sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_grf_write_scheduler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_addr = 5'd0;
    logic [31:0] pipe_data = 32'd0;
    logic [31:0] pipe_pc = 32'd0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [4:0]  md_addr = 5'd0;
    logic [31:0] md_data = 32'd0;
    logic [31:0] md_pc = 32'd0;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic [31:0] grf_pc;
    logic [4:0]  q1_addr = 5'd0;
    logic        q1_hit;
    logic [31:0] q1_data;
    logic [4:0]  q2_addr = 5'd0;
    logic        q2_hit;
    logic [31:0] q2_data;
    logic [2:0]  pending_cnt;
    logic        squash;

    int tests = 0;
    int failed = 0;

    grf_write_scheduler #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_pc(pipe_pc),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data), .md_pc(md_pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata), .grf_pc(grf_pc),
        .q1_addr(q1_addr), .q1_hit(q1_hit), .q1_data(q1_data),
        .q2_addr(q2_addr), .q2_hit(q2_hit), .q2_data(q2_data),
        .pending_cnt(pending_cnt), .squash(squash)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int pv, input int pa, input int pd, input int mv,
                         input int ma, input int md, input int qa1, input int qa2);
        pipe_valid = pv[0];
        pipe_addr  = pa[4:0];
        pipe_data  = pd;
        pipe_pc    = pd ^ 32'hC000_0000;
        md_valid   = mv[0];
        md_addr    = ma[4:0];
        md_data    = md;
        md_pc      = md ^ 32'hD000_0000;
        q1_addr    = qa1[4:0];
        q2_addr    = qa2[4:0];
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int pv, pa, pd, mv, ma, md, q;      // inputs (q drives both query ports)
        int eqh, eqd;                       // expected query result before the edge
        int ewe, ea, ed, epend, erdy, esq;  // expected registered outputs after the edge
    } vec_t;

    localparam int NV = 25;
    vec_t vec [NV];

    // ---------------- reference model ----------------
    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ment_t;

    ment_t       mq[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_pc;
    logic        m_sq;

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_pc = 32'd0; m_sq = 1'b0;
    endtask

    function automatic int model_live();
        int n = 0;
        foreach (mq[i]) if (mq[i].v) n++;
        return n;
    endfunction

    function automatic logic [32:0] model_query(input logic [4:0] qa);
        if (qa == 5'd0) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].v && mq[i].a == qa) return {1'b1, mq[i].d};
        if (m_we && m_addr == qa) return {1'b1, m_data};
        return 33'd0;
    endfunction

    // One clock of the spec rules, using the inputs currently driven
    task automatic model_step();
        bit    ready = mq.size() < DEPTH;
        bit    acc   = md_valid && ready && (md_addr != 5'd0);
        ment_t ne;
        ne = '{1'b1, md_addr, md_data, md_pc};
        while (mq.size() > 0 && !mq[0].v) void'(mq.pop_front());
        m_sq = 1'b0;
        if (pipe_valid && pipe_addr != 5'd0) begin
            foreach (mq[i]) if (mq[i].v && mq[i].a == pipe_addr) begin mq[i].v = 1'b0; m_sq = 1'b1; end
            m_we = 1'b1; m_addr = pipe_addr; m_data = pipe_data; m_pc = pipe_pc;
            if (acc) mq.push_back(ne);
        end else if (mq.size() > 0) begin
            m_we = 1'b1; m_addr = mq[0].a; m_data = mq[0].d; m_pc = mq[0].p;
            void'(mq.pop_front());
            if (acc) mq.push_back(ne);
        end else if (acc) begin
            m_we = 1'b1; m_addr = md_addr; m_data = md_data; m_pc = md_pc;
        end else begin
            m_we = 1'b0;
        end
    endtask

    initial begin
        logic [32:0] qr;
        int pprob;

        //         pv pa  pd      mv ma md      q   eqh eqd     ewe ea  ed      pend rdy sq
        vec[0]  = '{1, 5, 'h11,   0, 0, 0,      0,  0, 0,       1, 5,  'h11,   0, 1, 0};
        vec[1]  = '{0, 0, 0,      0, 0, 0,      5,  1, 'h11,    0, 0,  0,      0, 1, 0};
        vec[2]  = '{0, 0, 0,      1, 8, 'hAA,   5,  0, 0,       1, 8,  'hAA,   0, 1, 0};
        vec[3]  = '{0, 0, 0,      0, 0, 0,      8,  1, 'hAA,    0, 0,  0,      0, 1, 0};
        vec[4]  = '{1, 20,'h120,  1, 1, 'h201,  0,  0, 0,       1, 20, 'h120,  1, 1, 0};
        vec[5]  = '{1, 21,'h121,  1, 2, 'h202,  1,  1, 'h201,   1, 21, 'h121,  2, 1, 0};
        vec[6]  = '{1, 22,'h122,  1, 3, 'h203,  0,  0, 0,       1, 22, 'h122,  3, 1, 0};
        vec[7]  = '{1, 23,'h123,  1, 4, 'h204,  0,  0, 0,       1, 23, 'h123,  4, 0, 0};
        vec[8]  = '{1, 24,'h124,  1, 5, 'h205,  3,  1, 'h203,   1, 24, 'h124,  4, 0, 0};
        vec[9]  = '{1, 25,'h125,  1, 5, 'h205,  0,  0, 0,       1, 25, 'h125,  4, 0, 0};
        vec[10] = '{0, 0, 0,      1, 5, 'h205,  0,  0, 0,       1, 1,  'h201,  3, 1, 0};
        vec[11] = '{0, 0, 0,      1, 5, 'h205,  5,  0, 0,       1, 2,  'h202,  3, 1, 0};
        vec[12] = '{0, 0, 0,      0, 0, 0,      5,  1, 'h205,   1, 3,  'h203,  2, 1, 0};
        vec[13] = '{0, 0, 0,      0, 0, 0,      0,  0, 0,       1, 4,  'h204,  1, 1, 0};
        vec[14] = '{0, 0, 0,      0, 0, 0,      0,  0, 0,       1, 5,  'h205,  0, 1, 0};
        vec[15] = '{0, 0, 0,      0, 0, 0,      0,  0, 0,       0, 0,  0,      0, 1, 0};
        vec[16] = '{1, 9, 'h9,    1, 3, 'h1,    0,  0, 0,       1, 9,  'h9,    1, 1, 0};
        vec[17] = '{1, 3, 'h2,    0, 0, 0,      3,  1, 'h1,     1, 3,  'h2,    0, 1, 1};
        vec[18] = '{0, 0, 0,      0, 0, 0,      3,  1, 'h2,     0, 0,  0,      0, 1, 0};
        vec[19] = '{0, 0, 0,      0, 0, 0,      3,  0, 0,       0, 0,  0,      0, 1, 0};
        vec[20] = '{1, 0, 'h55,   1, 0, 'h66,   0,  0, 0,       0, 0,  0,      0, 1, 0};
        vec[21] = '{1, 0, 'h55,   1, 0, 'h66,   0,  0, 0,       0, 0,  0,      0, 1, 0};
        vec[22] = '{1, 7, 'h70,   1, 7, 'h77,   7,  0, 0,       1, 7,  'h70,   1, 1, 0};
        vec[23] = '{0, 0, 0,      0, 0, 0,      7,  1, 'h77,    1, 7,  'h77,   0, 1, 0};
        vec[24] = '{0, 0, 0,      0, 0, 0,      7,  1, 'h77,    0, 0,  0,      0, 1, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", grf_we, 0);
        chk("rst_addr", grf_addr, 0);
        chk("rst_wdata", grf_wdata, 0);
        chk("rst_pc", grf_pc, 0);
        chk("rst_pending", pending_cnt, 0);
        chk("rst_ready", md_ready, 1);
        chk("rst_squash", squash, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int r = 0; r < NV; r++) begin
            drive(vec[r].pv, vec[r].pa, vec[r].pd, vec[r].mv, vec[r].ma, vec[r].md, vec[r].q, vec[r].q);
            #3;
            chk($sformatf("v%0d_q1_hit", r), q1_hit, vec[r].eqh);
            chk($sformatf("v%0d_q1_data", r), q1_data, vec[r].eqd);
            chk($sformatf("v%0d_q2_hit", r), q2_hit, vec[r].eqh);
            chk($sformatf("v%0d_q2_data", r), q2_data, vec[r].eqd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", r), grf_we, vec[r].ewe);
            chk($sformatf("v%0d_pending", r), pending_cnt, vec[r].epend);
            chk($sformatf("v%0d_ready", r), md_ready, vec[r].erdy);
            chk($sformatf("v%0d_squash", r), squash, vec[r].esq);
            if (vec[r].ewe != 0) begin
                chk($sformatf("v%0d_addr", r), grf_addr, vec[r].ea);
                chk($sformatf("v%0d_wdata", r), grf_wdata, vec[r].ed);
            end
        end

        // Reset mid-operation with three queued results and a write in flight
        for (int k = 0; k < 3; k++) begin
            drive(1, 20 + k, 'h300 + k, 1, 1 + k, 'h400 + k, 0, 0);
            @(posedge clk);
            #1;
        end
        chk("pre_rst_pending", pending_cnt, 3);
        chk("pre_rst_we", grf_we, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", grf_we, 0);
        chk("mid_rst_pending", pending_cnt, 0);
        chk("mid_rst_ready", md_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_we%0d", k), grf_we, 0);
            chk($sformatf("post_rst_hit%0d", k), q1_hit, 0);
        end

        // Randomized traffic against the reference model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            pprob = ((c / 150) % 2 == 0) ? 25 : 80;
            drive(($urandom_range(0, 99) < pprob) ? 1 : 0, $urandom_range(0, 7), $urandom,
                  ($urandom_range(0, 99) < 60) ? 1 : 0, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 7), $urandom_range(0, 7));
            #3;
            chk("rnd_ready", md_ready, (mq.size() < DEPTH) ? 1 : 0);
            qr = model_query(q1_addr);
            chk("rnd_q1_hit", q1_hit, qr[32]);
            chk("rnd_q1_data", q1_data, qr[31:0]);
            qr = model_query(q2_addr);
            chk("rnd_q2_hit", q2_hit, qr[32]);
            chk("rnd_q2_data", q2_data, qr[31:0]);
            model_step();
            @(posedge clk);
            #1;
            chk("rnd_we", grf_we, m_we);
            chk("rnd_addr", grf_addr, m_addr);
            chk("rnd_wdata", grf_wdata, m_data);
            chk("rnd_pc", grf_pc, m_pc);
            chk("rnd_squash", squash, m_sq);
            chk("rnd_pending", pending_cnt, model_live());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
